// File: rtl/register_bank.sv
// Bank of NUM_REGS general-purpose registers sharing one data bus and one FunSel opcode.
// It has two combinational read ports, per-register zero flags and sticky wrap/clamp flags.
module register_bank #(
    parameter int               WIDTH       = 16,
    parameter int               NUM_REGS    = 4,
    parameter int               SATURATE    = 0,
    parameter logic [WIDTH-1:0] RESET_VALUE = '0,
    localparam int              SW          = (NUM_REGS > 2) ? $clog2(NUM_REGS) : 1
) (
    input  logic                Clock,
    input  logic                Reset,
    input  logic [WIDTH-1:0]    I,
    input  logic [2:0]          FunSel,
    input  logic [NUM_REGS-1:0] RegSel,
    input  logic [SW-1:0]       OutASel,
    input  logic [SW-1:0]       OutBSel,
    output logic [WIDTH-1:0]    OutA,
    output logic [WIDTH-1:0]    OutB,
    output logic [NUM_REGS-1:0] ZeroFlags,
    output logic [NUM_REGS-1:0] LimitFlags
);

    localparam int               H        = WIDTH / 2;
    localparam logic [WIDTH-1:0] ONE      = {{(WIDTH-1){1'b0}}, 1'b1};
    localparam logic [WIDTH-1:0] ALL_ONES = '1;

    typedef enum logic [2:0] {
        OP_DEC        = 3'b000,
        OP_INC        = 3'b001,
        OP_LOAD       = 3'b010,
        OP_CLEAR      = 3'b011,
        OP_LOAD_LOW   = 3'b100,
        OP_WRITE_LOW  = 3'b101,
        OP_WRITE_HIGH = 3'b110,
        OP_SEXT_LOW   = 3'b111
    } op_e;

    op_e                 op;
    logic [H-1:0]        low_in;
    logic [WIDTH-1:0]    regs_q [NUM_REGS];
    logic [WIDTH-1:0]    regs_d [NUM_REGS];
    logic [NUM_REGS-1:0] limit_q;
    logic [NUM_REGS-1:0] limit_d;

    assign op     = op_e'(FunSel);
    assign low_in = I[H-1:0];

    always_comb begin
        // NOTE: hold-by-default assignments come first, so unselected registers keep their value and no latch is inferred.
        regs_d  = regs_q;
        limit_d = limit_q;
        for (int k = 0; k < NUM_REGS; k++) begin
            if (RegSel[k]) begin
                unique case (op)
                    OP_DEC: begin
                        if (regs_q[k] == '0) begin
                            limit_d[k] = 1'b1;
                            regs_d[k]  = (SATURATE != 0) ? '0 : ALL_ONES;
                        end else begin
                            regs_d[k] = regs_q[k] - ONE;
                        end
                    end
                    OP_INC: begin
                        if (regs_q[k] == ALL_ONES) begin
                            limit_d[k] = 1'b1;
                            regs_d[k]  = (SATURATE != 0) ? ALL_ONES : '0;
                        end else begin
                            regs_d[k] = regs_q[k] + ONE;
                        end
                    end
                    OP_LOAD:       regs_d[k] = I;
                    OP_CLEAR: begin
                        regs_d[k]  = '0;
                        limit_d[k] = 1'b0;
                    end
                    OP_LOAD_LOW:   regs_d[k] = {{H{1'b0}}, low_in};
                    OP_WRITE_LOW:  regs_d[k][H-1:0] = low_in;
                    OP_WRITE_HIGH: regs_d[k][WIDTH-1:H] = low_in;
                    OP_SEXT_LOW:   regs_d[k] = {{H{low_in[H-1]}}, low_in};
                    default:       ;
                endcase
            end
        end
    end

    always_ff @(posedge Clock) begin
        if (Reset) begin
            // NOTE: the register array itself is reset, so read ports and ZeroFlags are defined from the first reset.
            for (int k = 0; k < NUM_REGS; k++) begin
                regs_q[k] <= RESET_VALUE;
            end
            limit_q <= '0;
        end else begin
            // NOTE: non-blocking updates make every register see pre-edge values of the whole bank.
            regs_q  <= regs_d;
            limit_q <= limit_d;
        end
    end

    // Unmatched addresses (>= NUM_REGS) fall through to zero.
    always_comb begin
        OutA      = '0;
        OutB      = '0;
        ZeroFlags = '0;
        for (int k = 0; k < NUM_REGS; k++) begin
            if (OutASel == k[SW-1:0]) OutA = regs_q[k];
            if (OutBSel == k[SW-1:0]) OutB = regs_q[k];
            ZeroFlags[k] = (regs_q[k] == '0);
        end
    end

    assign LimitFlags = limit_q;

endmodule

// File: tb/tb_register_bank.sv
// Scoreboard bench for register_bank: two configurations driven by one stimulus stream,
// each checked against an arithmetic reference model of the register rules.
module tb_register_bank;

    logic        clk = 1'b0;
    logic        rst;
    logic [15:0] data;
    logic [2:0]  fun;
    logic [3:0]  reg_sel;
    logic [1:0]  a_sel;
    logic [1:0]  b_sel;

    logic [15:0] a_outa, a_outb, b_outa, b_outb;
    logic [3:0]  a_zero, a_limit;
    logic [2:0]  b_zero, b_limit;

    always #5 clk = ~clk;

    register_bank #(.WIDTH(16), .NUM_REGS(4), .SATURATE(0), .RESET_VALUE(16'h0000)) dut_a (
        .Clock(clk), .Reset(rst), .I(data), .FunSel(fun), .RegSel(reg_sel),
        .OutASel(a_sel), .OutBSel(b_sel), .OutA(a_outa), .OutB(a_outb),
        .ZeroFlags(a_zero), .LimitFlags(a_limit)
    );

    register_bank #(.WIDTH(16), .NUM_REGS(3), .SATURATE(1), .RESET_VALUE(16'h1234)) dut_b (
        .Clock(clk), .Reset(rst), .I(data), .FunSel(fun), .RegSel(reg_sel[2:0]),
        .OutASel(a_sel), .OutBSel(b_sel), .OutA(b_outa), .OutB(b_outb),
        .ZeroFlags(b_zero), .LimitFlags(b_limit)
    );

    typedef struct {
        bit          skip;
        logic [15:0] a_oa, a_ob, b_oa, b_ob;
        logic [3:0]  a_z, a_l;
        logic [2:0]  b_z, b_l;
    } exp_t;

    exp_t sb[$];
    int   n_checks = 0;
    int   n_fails  = 0;

    // Reference model: index 0 = dut_a, index 1 = dut_b.
    int   m_regs [2][4];
    bit   m_lim  [2][4];
    int   n_regs [2];
    int   sat    [2];
    int   rv     [2];
    bit   model_init = 1'b0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fails++;
            $display("FAIL %s at %0t: got 0x%0h expected 0x%0h", name, $time, act, exp);
        end
    endtask

    function automatic int rd(input int d, input int sel);
        return (sel < n_regs[d]) ? m_regs[d][sel] : 0;
    endfunction

    function automatic void model_step(input int d, input bit r, input int i, input int f, input int rs);
        int low = i & 'hFF;
        for (int k = 0; k < n_regs[d]; k++) begin
            if (r) begin
                m_regs[d][k] = rv[d];
                m_lim[d][k]  = 1'b0;
            end else if (rs[k]) begin
                case (f)
                    0: if (m_regs[d][k] == 0) begin
                           m_lim[d][k]  = 1'b1;
                           m_regs[d][k] = (sat[d] != 0) ? 0 : 'hFFFF;
                       end else m_regs[d][k] = m_regs[d][k] - 1;
                    1: if (m_regs[d][k] == 'hFFFF) begin
                           m_lim[d][k]  = 1'b1;
                           m_regs[d][k] = (sat[d] != 0) ? 'hFFFF : 0;
                       end else m_regs[d][k] = m_regs[d][k] + 1;
                    2: m_regs[d][k] = i;
                    3: begin m_regs[d][k] = 0; m_lim[d][k] = 1'b0; end
                    4: m_regs[d][k] = low;
                    5: m_regs[d][k] = (m_regs[d][k] & 'hFF00) | low;
                    6: m_regs[d][k] = (m_regs[d][k] & 'h00FF) | (low * 256);
                    default: m_regs[d][k] = (low >= 128) ? (low + 'hFF00) : low;
                endcase
            end
        end
    endfunction

    function automatic exp_t snapshot(input bit skip, input int a, input int b);
        exp_t e;
        e.skip = skip;
        e.a_oa = 16'(rd(0, a));
        e.a_ob = 16'(rd(0, b));
        e.b_oa = 16'(rd(1, a));
        e.b_ob = 16'(rd(1, b));
        e.a_z  = '0; e.a_l = '0; e.b_z = '0; e.b_l = '0;
        for (int k = 0; k < 4; k++) begin
            e.a_z[k] = (m_regs[0][k] == 0);
            e.a_l[k] = m_lim[0][k];
        end
        for (int k = 0; k < 3; k++) begin
            e.b_z[k] = (m_regs[1][k] == 0);
            e.b_l[k] = m_lim[1][k];
        end
        return e;
    endfunction

    // One clock of stimulus: the first record covers the pre-edge read (new selects, old state),
    // the second the state after the edge.
    task automatic drive(input bit r, input logic [15:0] i, input logic [2:0] f,
                         input logic [3:0] rs, input logic [1:0] a, input logic [1:0] b);
        @(negedge clk);
        rst = r; data = i; fun = f; reg_sel = rs; a_sel = a; b_sel = b;
        sb.push_back(snapshot(!model_init, int'(a), int'(b)));
        model_step(0, r, int'(i), int'(f), int'(rs));
        model_step(1, r, int'(i), int'(f), int'(rs));
        if (r) model_init = 1'b1;
        sb.push_back(snapshot(!model_init, int'(a), int'(b)));
    endtask

    initial begin : monitor
        exp_t e;
        forever begin
            @(clk);
            #1;
            if (sb.size() > 0) begin
                e = sb.pop_front();
                if (!e.skip) begin
                    check("a_OutA",       32'(a_outa),  32'(e.a_oa));
                    check("a_OutB",       32'(a_outb),  32'(e.a_ob));
                    check("a_ZeroFlags",  32'(a_zero),  32'(e.a_z));
                    check("a_LimitFlags", 32'(a_limit), 32'(e.a_l));
                    check("b_OutA",       32'(b_outa),  32'(e.b_oa));
                    check("b_OutB",       32'(b_outb),  32'(e.b_ob));
                    check("b_ZeroFlags",  32'(b_zero),  32'(e.b_z));
                    check("b_LimitFlags", 32'(b_limit), 32'(e.b_l));
                end
            end
        end
    end

    initial begin : watchdog
        #500000;
        $display("FAIL watchdog: simulation time limit reached, %0d checks, %0d failures", n_checks, n_fails);
        $fatal(1, "watchdog");
    end

    initial begin : stimulus
        logic [15:0] rnd_i;
        n_regs = '{4, 3};
        sat    = '{0, 1};
        rv     = '{0, 'h1234};
        for (int d = 0; d < 2; d++)
            for (int k = 0; k < 4; k++) begin
                m_regs[d][k] = 0;
                m_lim[d][k]  = 1'b0;
            end
        rst = 1'b1; data = '0; fun = '0; reg_sel = '0; a_sel = '0; b_sel = '0;

        // Reset state and every read address.
        drive(1'b1, 16'h0000, 3'b000, 4'b0000, 2'd0, 2'd1);
        for (int a = 0; a < 4; a++) drive(1'b0, 16'h0000, 3'b010, 4'b0000, 2'(a), 2'(3 - a));

        // Loads and half-word operations.
        drive(1'b0, 16'hABCD, 3'b010, 4'b0101, 2'd0, 2'd2);
        drive(1'b0, 16'h0080, 3'b111, 4'b0001, 2'd0, 2'd1);
        drive(1'b0, 16'h0080, 3'b100, 4'b0100, 2'd2, 2'd0);
        drive(1'b0, 16'h0012, 3'b110, 4'b0100, 2'd2, 2'd2);
        drive(1'b0, 16'h0034, 3'b101, 4'b0100, 2'd2, 2'd3);

        // Wrap at the top, wrap at the bottom, then clear.
        drive(1'b0, 16'hFFFF, 3'b010, 4'b0010, 2'd1, 2'd1);
        drive(1'b0, 16'h0000, 3'b001, 4'b0010, 2'd1, 2'd0);
        drive(1'b0, 16'h0000, 3'b000, 4'b0010, 2'd1, 2'd0);
        drive(1'b0, 16'h0000, 3'b011, 4'b0010, 2'd1, 2'd0);

        // Repeated decrement at zero, then increment into the all-ones limit.
        drive(1'b0, 16'h0000, 3'b011, 4'b1100, 2'd3, 2'd2);
        repeat (3) drive(1'b0, 16'h0000, 3'b000, 4'b1100, 2'd3, 2'd2);
        drive(1'b0, 16'hFFFE, 3'b010, 4'b1100, 2'd3, 2'd2);
        repeat (2) drive(1'b0, 16'h0000, 3'b001, 4'b1100, 2'd3, 2'd2);

        // Read timing on a shared address and an out-of-range address.
        drive(1'b0, 16'h5555, 3'b010, 4'b0100, 2'd2, 2'd2);
        drive(1'b0, 16'h0000, 3'b010, 4'b0000, 2'd3, 2'd2);

        // Reset arriving in the middle of an increment sequence.
        drive(1'b0, 16'hFFFF, 3'b010, 4'b0001, 2'd0, 2'd0);
        drive(1'b0, 16'h0000, 3'b001, 4'b0001, 2'd0, 2'd0);
        drive(1'b0, 16'h0010, 3'b010, 4'b0001, 2'd0, 2'd0);
        repeat (2) drive(1'b0, 16'h0000, 3'b001, 4'b0001, 2'd0, 2'd0);
        drive(1'b1, 16'h0000, 3'b001, 4'b0001, 2'd0, 2'd0);
        repeat (2) drive(1'b0, 16'h0000, 3'b001, 4'b0001, 2'd0, 2'd0);

        // Random traffic biased toward the limit values.
        for (int n = 0; n < 1500; n++) begin
            case ($urandom_range(0, 4))
                0:       rnd_i = 16'h0000;
                1:       rnd_i = 16'hFFFF;
                2:       rnd_i = 16'hFFFE;
                3:       rnd_i = 16'h0001;
                default: rnd_i = 16'($urandom);
            endcase
            drive(($urandom_range(0, 49) == 0), rnd_i, 3'($urandom_range(0, 7)),
                  4'($urandom), 2'($urandom_range(0, 3)), 2'($urandom_range(0, 3)));
        end

        repeat (3) @(posedge clk);
        #2;
        check("scoreboard_drained", 32'(sb.size()), 32'd0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
        $finish;
    end

endmodule

// File: doc/register_bank.md
Name: register_bank

Overview:
- Parametrised bank of NUM_REGS general-purpose registers, each WIDTH bits wide, sharing one input bus and one 3-bit FunSel operation code.
- The operation applies in the same cycle to every register whose RegSel bit is set.
- Two combinational read ports and per-register status flags, including a sticky limit flag that records overflow/underflow.
- Next-generation replacement for the single 16-bit function-select register in the datapath. Adds synchronous reset, an optional saturating mode and multi-register addressing.

Parameters:
- WIDTH, 16: register width in bits. Must be even and >= 4. H = WIDTH/2 is the half-word width.
- NUM_REGS, 4: number of registers, 2..16. SW = max(1, ceil(log2(NUM_REGS))).
- SATURATE, 0: 0 = increment/decrement wrap modulo 2^WIDTH; 1 = increment/decrement clamp at the limits.
- RESET_VALUE, 0: WIDTH-bit value loaded into every register on reset.

Ports:
- Clock  in  1  rising-edge clock.
- Reset  in  1  synchronous active-high reset; one clock, reset is synchronous and active-high.
- I  in  WIDTH  input data bus.
- FunSel  in  3  operation code applied to selected registers.
- RegSel  in  NUM_REGS  per-register enable mask; bit k enables register k.
- OutASel  in  SW  read-port A address.
- OutBSel  in  SW  read-port B address.
- OutA  out  WIDTH  contents of register OutASel.
- OutB  out  WIDTH  contents of register OutBSel.
- ZeroFlags  out  NUM_REGS  bit k = 1 when register k == 0.
- LimitFlags  out  NUM_REGS  sticky bit k = 1 after register k hit a wrap/clamp event.

Behaviour:
- All state updates on the rising edge of Clock. Reset has priority over everything else.
- Reset = 1 at an edge:
  - every register <= RESET_VALUE;
  - LimitFlags <= 0;
  - RegSel and FunSel are ignored that cycle.
  - Reset asserted mid-sequence simply overrides the operation in flight; nothing is carried forward.
- Register k with RegSel[k] = 0 holds its value and its LimitFlags bit.
- Register k with RegSel[k] = 1 applies FunSel. Here Q = current value of register k, L = I[H-1:0]:
  - 000 decrement: Q-1. At Q = 0: SATURATE=0 gives all-ones; SATURATE=1 holds 0. Either way LimitFlags[k] <= 1.
  - 001 increment: Q+1. At Q = all-ones: SATURATE=0 gives 0; SATURATE=1 holds all-ones. Either way LimitFlags[k] <= 1.
  - 010 load: Q <= I.
  - 011 clear: Q <= 0 and LimitFlags[k] <= 0. This is the only non-reset way to clear the flag.
  - 100 load low, zero high: Q <= {H zeros, L}.
  - 101 write low: Q[H-1:0] <= L; upper half unchanged.
  - 110 write high: Q[WIDTH-1:H] <= L; lower half unchanged.
  - 111 sign-extend low: Q <= {H copies of I[H-1], L}.
- Operations other than 000/001/011 leave LimitFlags[k] unchanged.
- Multiple RegSel bits set: every selected register performs the same operation on its own value in the same cycle. Registers are independent, and flags are per register.
- Read ports:
  - combinational from register state, zero latency;
  - a value written at edge n is visible on OutA/OutB after edge n; no write-through in the same cycle;
  - OutASel/OutBSel may be equal;
  - an address >= NUM_REGS drives the port to 0.
- ZeroFlags is combinational from register state. LimitFlags is registered.
- No X propagation: all outputs are defined from the first reset onward.

Test Plan (WIDTH=16, NUM_REGS=4 unless noted):
1. Reset, then read all addresses -> OutA = OutB = 0x0000, ZeroFlags = 4'b1111, LimitFlags = 0. Repeat with RESET_VALUE = 0x1234 -> OutA = 0x1234, ZeroFlags = 0.
2. I=0xABCD, FunSel=010, RegSel=4'b0101 -> R0 = R2 = 0xABCD, R1 = R3 = 0. Then I=0x0080 with FunSel=111 on R0 -> 0xFF80. Then FunSel=100 on R2 -> 0x0080. Then I=0x0012, FunSel=110 on R2 -> 0x1280. Then I=0x0034, FunSel=101 on R2 -> 0x1234.
3. SATURATE=0: R1 = 0xFFFF, FunSel=001 -> R1 = 0x0000, LimitFlags[1]=1, ZeroFlags[1]=1. Then FunSel=000 -> 0xFFFF, flag stays 1. Then FunSel=011 -> 0, LimitFlags[1]=0.
4. SATURATE=1: R3 = 0x0000, FunSel=000 three times -> R3 stays 0x0000, LimitFlags[3]=1. Load 0xFFFE, FunSel=001 twice -> 0xFFFF, 0xFFFF.
5. Read timing: load 0x5555 into R2 with OutASel = OutBSel = 2 -> old value in the load cycle, 0x5555 after the edge. NUM_REGS=3 with OutASel=3 -> OutA = 0.
6. Reset mid-operation: R0 incrementing each cycle from 0x0010 with LimitFlags[0]=1 from an earlier wrap; assert Reset together with RegSel/FunSel=001 -> next value 0x0000, LimitFlags = 0. Incrementing resumes only once Reset deasserts.
